router_controller_mp: RTL and testbench
=======================================

ROUTER_CONTROLLER_MP -- requirements
Module: router_controller_mp

Interface
REQ-001 SHALL have parameters: AURORA_DATA_WIDTH, default 64, crossbar data width (passed through, unused internally); ADDR_WIDTH, default 10, address width; NUM_PORTS, default 4, number of ports (2..16); NUMBER_PACKET, default 19, beats per transfer (>=1); TIMEOUT_CYCLES, default 255, watchdog limit.
REQ-002 SHALL derive PORT_W = $clog2(NUM_PORTS) and CNT_W = $clog2(NUMBER_PACKET+1).
REQ-003 SHALL have one clock and a synchronous, active-high reset. Ports:
 clk  in  1  clock, all logic on rising edge
 rst  in  1  synchronous active-high reset
 router_start_req  in  NUM_PORTS  per-source transfer request, held until acked
 router_dst_port  in  NUM_PORTS*PORT_W  destination port per source
 router_dst_addr  in  NUM_PORTS*ADDR_WIDTH  destination address per source
 router_start_ack  out  NUM_PORTS  one-cycle accept pulse, one-hot
 router_done  out  NUM_PORTS  one-cycle completion pulse, one-hot
 router_err  out  1  one-cycle timeout-abort pulse, coincident with router_done
 busy  out  1  high whenever state != IDLE
 write_req  out  1  memory-arbiter request
 write_gnt  in  1  memory-arbiter grant
 addr  out  ADDR_WIDTH  latched destination address
 empty_input_port  in  NUM_PORTS  input FIFO empty flags (first-word-fall-through)
 rd_input_port  out  NUM_PORTS  input FIFO read strobes
 full_output_port  in  NUM_PORTS  output FIFO full flags
 we_output_port  out  NUM_PORTS  output FIFO write strobes
 crossbar_sel  out  NUM_PORTS*PORT_W  per output port, selected input index
 crossbar_en  out  NUM_PORTS  per output port, crossbar path enable

Function
REQ-004 SHALL implement FSM states IDLE, ARB, XFER, DONE.
REQ-005 IDLE: if any router_start_req bit high, SHALL select one by round-robin starting at (last_granted+1) mod NUM_PORTS, latch src, dst_port, dst_addr, go to ARB; else stay.
REQ-006 SHALL pulse router_start_ack[src] in the first ARB cycle only; request bits deasserted before selection are ignored.
REQ-007 ARB and XFER SHALL assert write_req and drive addr = latched dst_addr; ARB -> XFER on write_gnt sampled high.
REQ-008 XFER SHALL drive crossbar_en[dst]=1 and crossbar_sel[dst]=src; all other crossbar_en bits 0, unselected crossbar_sel fields 0.
REQ-009 Beat condition (combinational, XFER): !empty_input_port[src] && !full_output_port[dst] && write_gnt && count<NUMBER_PACKET; on beat rd_input_port[src] and we_output_port[dst] SHALL both assert in that cycle and count SHALL increment.
REQ-010 write_gnt low during XFER SHALL stall beats without leaving XFER.
REQ-011 After the beat making count==NUMBER_PACKET, SHALL enter DONE next cycle; DONE SHALL pulse router_done[src], deassert write_req, clear count, set last_granted=src, return to IDLE.
REQ-012 src==dst_port (loopback) SHALL be legal and behave identically.
REQ-013 dst_port >= NUM_PORTS SHALL be treated as dst_port mod 2^PORT_W truncated; behaviour otherwise undefined (bench must not drive).
REQ-014 Strobes rd_input_port/we_output_port SHALL never assert outside XFER; at most one bit of each asserted per cycle.
REQ-015 Minimum latency: request in IDLE cycle 0 -> ack cycle 1; with write_gnt already high, first beat cycle 2; done pulse cycle 2+NUMBER_PACKET; next request accepted in IDLE the following cycle.

Reset
REQ-016 rst SHALL, in any state including mid-XFER, force state IDLE, count 0, last_granted NUM_PORTS-1 (port 0 wins first), all outputs 0.
REQ-017 Outputs SHALL be 0 in the cycle after rst sampled high; no done/err pulse emitted for an aborted transfer.

Configuration
REQ-018 Macro ROUTER_CTRL_TIMEOUT_EN: when defined, XFER SHALL count consecutive non-beat cycles; on reaching TIMEOUT_CYCLES SHALL go to DONE and pulse router_err with router_done[src]; counter clears on every beat.
REQ-019 Without ROUTER_CTRL_TIMEOUT_EN, router_err SHALL be tied 0, no watchdog logic present, XFER may stall indefinitely.

Verification
REQ-020 Single: req[1], dst_port=3, dst_addr=0x0A, gnt high, FIFOs ready -> ack[1] cycle 1, addr=0x0A, 19 beats rd[1]/we[3] cycles 2..20, crossbar_sel[3]=1, done[1] cycle 21.
REQ-021 Contention: req=4'b1111 after reset -> grant order 0,1,2,3, each with 19 beats and one done pulse.
REQ-022 Backpressure: full_output_port[2] high for cycles 5..9 of transfer 0->2 -> no beats those cycles, total still 19, done delayed 5 cycles.
REQ-023 Grant stall: write_gnt low 10 cycles in XFER -> beats stop, write_req stays high, resume when gnt returns.
REQ-024 Reset mid-transfer: rst after beat 7 -> all outputs 0 next cycle, no done; next request granted to port 0 first.
REQ-025 With ROUTER_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: empty_input_port[src] stuck high -> router_err and router_done[src] pulse after 16 idle cycles; without macro, busy stays high.

Source files
------------

// File: rtl/router_controller_mp.sv
// router_controller_mp: round-robin crossbar transfer controller.
// Accepts one source request at a time, arbitrates for the memory port,
// then moves NUMBER_PACKET beats from the source input FIFO to the
// destination output FIFO through the crossbar before pulsing done.
//
// Optional feature macro: ROUTER_CTRL_TIMEOUT_EN adds an XFER watchdog that
// aborts after TIMEOUT_CYCLES consecutive non-beat cycles (router_err).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   router_start_req/dst_port/addr   per-source requests and routing info
//   router_start_ack, router_done    one-hot accept / completion pulses
//   router_err                       watchdog abort pulse (with done)
//   busy                             controller not idle
//   write_req/write_gnt, addr        memory-arbiter handshake and address
//   empty_input_port, rd_input_port  input FIFO status / read strobes
//   full_output_port, we_output_port output FIFO status / write strobes
//   crossbar_sel, crossbar_en        per-output-port crossbar control
module router_controller_mp #(
    parameter int unsigned AURORA_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH        = 10,
    parameter int unsigned NUM_PORTS         = 4,
    parameter int unsigned NUMBER_PACKET     = 19,
    parameter int unsigned TIMEOUT_CYCLES    = 255,
    localparam int unsigned PORT_W = $clog2(NUM_PORTS),
    localparam int unsigned CNT_W  = $clog2(NUMBER_PACKET + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            router_start_req,
    input  logic [NUM_PORTS*PORT_W-1:0]     router_dst_port,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] router_dst_addr,
    output logic [NUM_PORTS-1:0]            router_start_ack,
    output logic [NUM_PORTS-1:0]            router_done,
    output logic                            router_err,
    output logic                            busy,
    output logic                            write_req,
    input  logic                            write_gnt,
    output logic [ADDR_WIDTH-1:0]           addr,
    input  logic [NUM_PORTS-1:0]            empty_input_port,
    output logic [NUM_PORTS-1:0]            rd_input_port,
    input  logic [NUM_PORTS-1:0]            full_output_port,
    output logic [NUM_PORTS-1:0]            we_output_port,
    output logic [NUM_PORTS*PORT_W-1:0]     crossbar_sel,
    output logic [NUM_PORTS-1:0]            crossbar_en
);

    // Elaboration-time sanity check of the configuration.
    if (NUM_PORTS < 2 || NUMBER_PACKET < 1 || AURORA_DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1)
    begin : g_cfg_check
        $error("router_controller_mp: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;

    state_t                  state_q, state_d;
    logic [PORT_W-1:0]       src_q, src_d, dst_q, dst_d, last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    first_q, first_d;

    logic                    pick_vld;
    logic [PORT_W-1:0]       pick, idx, pick_dst;
    logic [ADDR_WIDTH-1:0]   pick_addr;
    logic                    src_empty, dst_full, beat_c;

`ifdef ROUTER_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    err_q, err_d;
`else
    assign router_err = 1'b0;
`endif

    // Round-robin pick starting just after the last granted source.
    always_comb begin
        pick_vld  = 1'b0;
        pick      = '0;
        idx       = '0;
        pick_dst  = '0;
        pick_addr = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = PORT_W'((32'(last_q) + i) % NUM_PORTS);
            if (!pick_vld && router_start_req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (PORT_W'(p) == pick) begin
                pick_dst  = router_dst_port[p*PORT_W +: PORT_W];
                pick_addr = router_dst_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // FIFO status of the latched source / destination.
    always_comb begin
        src_empty = 1'b1;
        dst_full  = 1'b1;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (PORT_W'(p) == src_q) src_empty = empty_input_port[p];
            if (PORT_W'(p) == dst_q) dst_full  = full_output_port[p];
        end
    end

    assign beat_c = (state_q == XFER) && !src_empty && !dst_full && write_gnt
                    && (cnt_q < CNT_W'(NUMBER_PACKET));

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        src_d            = src_q;
        dst_d            = dst_q;
        addr_d           = addr_q;
        cnt_d            = cnt_q;
        last_d           = last_q;
        first_d          = 1'b0;
        router_start_ack = '0;
        router_done      = '0;
        busy             = (state_q != IDLE);
        write_req        = 1'b0;
        addr             = '0;
        rd_input_port    = '0;
        we_output_port   = '0;
        crossbar_sel     = '0;
        crossbar_en      = '0;
`ifdef ROUTER_CTRL_TIMEOUT_EN
        wd_d             = wd_q;
        err_d            = err_q;
        router_err       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ARB;
                    src_d   = pick;
                    dst_d   = pick_dst;
                    addr_d  = pick_addr;
                    cnt_d   = '0;
                    first_d = 1'b1;
`ifdef ROUTER_CTRL_TIMEOUT_EN
                    wd_d    = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ARB: begin
                write_req = 1'b1;
                addr      = addr_q;
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (first_q && PORT_W'(p) == src_q) router_start_ack[p] = 1'b1;
                end
                if (write_gnt) state_d = XFER;
            end
            XFER: begin
                write_req = 1'b1;
                addr      = addr_q;
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (PORT_W'(p) == dst_q) begin
                        crossbar_en[p]                    = 1'b1;
                        crossbar_sel[p*PORT_W +: PORT_W]  = src_q;
                        we_output_port[p]                 = beat_c;
                    end
                    if (PORT_W'(p) == src_q) rd_input_port[p] = beat_c;
                end
                if (beat_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUMBER_PACKET - 1)) state_d = DONE;
`ifdef ROUTER_CTRL_TIMEOUT_EN
                    wd_d = '0;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            DONE: begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (PORT_W'(p) == src_q) router_done[p] = 1'b1;
                end
`ifdef ROUTER_CTRL_TIMEOUT_EN
                router_err = err_q;
                err_d      = 1'b0;
                wd_d       = '0;
`endif
                cnt_d   = '0;
                last_d  = src_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= PORT_W'(NUM_PORTS - 1);
            first_q <= 1'b0;
`ifdef ROUTER_CTRL_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            first_q <= first_d;
`ifdef ROUTER_CTRL_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_router_controller_mp.sv
// Bench for router_controller_mp: transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed timing.
module tb_router_controller_mp;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int AW = 10;
    localparam int NP = 19;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    router_start_req;
    logic [N*PW-1:0] router_dst_port;
    logic [N*AW-1:0] router_dst_addr;
    logic [N-1:0]    router_start_ack, router_done;
    logic            router_err, busy, write_req, write_gnt;
    logic [AW-1:0]   addr;
    logic [N-1:0]    empty_input_port, rd_input_port, full_output_port, we_output_port;
    logic [N*PW-1:0] crossbar_sel;
    logic [N-1:0]    crossbar_en;

    router_controller_mp #(
        .AURORA_DATA_WIDTH(64), .ADDR_WIDTH(AW), .NUM_PORTS(N),
        .NUMBER_PACKET(NP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .router_start_req(router_start_req), .router_dst_port(router_dst_port),
        .router_dst_addr(router_dst_addr), .router_start_ack(router_start_ack),
        .router_done(router_done), .router_err(router_err), .busy(busy),
        .write_req(write_req), .write_gnt(write_gnt), .addr(addr),
        .empty_input_port(empty_input_port), .rd_input_port(rd_input_port),
        .full_output_port(full_output_port), .we_output_port(we_output_port),
        .crossbar_sel(crossbar_sel), .crossbar_en(crossbar_en)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    function automatic void check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, ncyc, act, exp);
        end
    endfunction

    // Events observed on the DUT, used only for the literal timing checks.
    int ack_log[$];
    int done_beats[$];
    int ack_tot[N];
    int ack_cyc = -1, first_beat = -1, done_cyc = -1, beat_cnt = 0, done_cnt = 0;
    logic [AW-1:0]   ack_addr;
    logic [N*PW-1:0] first_sel;

    // Reference model: one transfer in flight, described by its progress.
    bit m_valid = 0, m_active = 0, m_first = 0, m_granted = 0, m_fin = 0, m_err = 0;
    int m_beats, m_idle, m_last, m_src, m_dst, m_addr;

    always @(negedge clk) begin
        logic [N-1:0]    e_ack, e_done, e_rd, e_we, e_en;
        logic [N*PW-1:0] e_sel;
        logic            e_wreq, e_err, beat;
        logic [AW-1:0]   e_addr;
        bit              found;
        ncyc++;

        for (int p = 0; p < N; p++) begin
            if (router_start_ack[p]) begin
                ack_log.push_back(p);
                ack_tot[p]++;
                ack_cyc  = ncyc;
                ack_addr = addr;
                beat_cnt = 0;
            end
        end
        if (rd_input_port != 0) begin
            if (beat_cnt == 0) begin
                first_beat = ncyc;
                first_sel  = crossbar_sel;
            end
            beat_cnt++;
        end
        if (router_done != 0) begin
            done_cyc = ncyc;
            done_cnt++;
            done_beats.push_back(beat_cnt);
        end

        e_ack = '0; e_done = '0; e_rd = '0; e_we = '0; e_en = '0; e_sel = '0;
        e_err = 1'b0; beat = 1'b0;
        e_wreq = m_active && !m_fin;
        e_addr = e_wreq ? AW'(m_addr) : '0;
        if (m_active && m_first) e_ack[m_src] = 1'b1;
        if (m_active && m_granted && !m_fin) begin
            e_en[m_dst] = 1'b1;
            e_sel[m_dst*PW +: PW] = PW'(m_src);
            beat = !empty_input_port[m_src] && !full_output_port[m_dst] && write_gnt && m_beats < NP;
            if (beat) begin
                e_rd[m_src] = 1'b1;
                e_we[m_dst] = 1'b1;
            end
        end
        if (m_fin) begin
            e_done[m_src] = 1'b1;
            e_err = m_err;
        end

        if (m_valid) begin
            check("ack",       router_start_ack, e_ack);
            check("done",      router_done,      e_done);
            check("err",       router_err,       e_err);
            check("busy",      busy,             m_active);
            check("write_req", write_req,        e_wreq);
            check("addr",      addr,             e_addr);
            check("rd",        rd_input_port,    e_rd);
            check("we",        we_output_port,   e_we);
            check("xbar_en",   crossbar_en,      e_en);
            check("xbar_sel",  crossbar_sel,     e_sel);
        end

        if (rst) begin
            m_valid = 1; m_active = 0; m_first = 0; m_granted = 0; m_fin = 0;
            m_err = 0; m_beats = 0; m_idle = 0; m_last = N - 1;
        end else if (m_valid) begin
            if (!m_active) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (!found && router_start_req[j]) begin
                        found = 1; m_active = 1; m_first = 1; m_granted = 0;
                        m_fin = 0; m_err = 0; m_beats = 0; m_idle = 0; m_src = j;
                        m_dst  = int'(router_dst_port[j*PW +: PW]);
                        m_addr = int'(router_dst_addr[j*AW +: AW]);
                    end
                end
            end else if (m_fin) begin
                m_active = 0; m_fin = 0; m_last = m_src;
            end else if (!m_granted) begin
                m_first = 0;
                if (write_gnt) m_granted = 1;
            end else begin
                if (beat) begin
                    m_beats++;
                    m_idle = 0;
                    if (m_beats == NP) m_fin = 1;
                end else begin
                    m_idle++;
`ifdef ROUTER_CTRL_TIMEOUT_EN
                    if (m_idle == TO) begin m_fin = 1; m_err = 1; end
`endif
                end
            end
        end
    end

    // Stimulus helpers: requests are held until their ack has been seen.
    int rel_tot[N];
    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (ack_tot[p] != rel_tot[p]) begin
                router_start_req[p] = 1'b0;
                rel_tot[p] = ack_tot[p];
            end
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_done_seen"}, done_cnt > start, 1);
    endtask

    task automatic set_route(input int s, input int d, input int a);
        router_dst_port[s*PW +: PW] = PW'(d);
        router_dst_addr[s*AW +: AW] = AW'(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", ncyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0, base, dc;
        rst = 1'b1; router_start_req = '0; router_dst_port = '0; router_dst_addr = '0;
        write_gnt = 1'b0; empty_input_port = '1; full_output_port = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_outs", {router_start_ack, router_done, rd_input_port, we_output_port,
                           crossbar_en, crossbar_sel, write_req, router_err, addr}, 0);

        write_gnt = 1'b1;
        empty_input_port = '0;

        // Single transfer 1 -> 3.
        set_route(1, 3, 'h0A);
        router_start_req[1] = 1'b1;
        c0 = ncyc + 1;
        wait_done("t1", 60);
        check("t1_ack_cyc",     ack_cyc,        c0 + 1);
        check("t1_ack_port",    ack_log[ack_log.size()-1], 1);
        check("t1_addr",        ack_addr,       'h0A);
        check("t1_first_beat",  first_beat,     c0 + 2);
        check("t1_sel3",        first_sel[7:6], 1);
        check("t1_done_cyc",    done_cyc,       c0 + 21);
        check("t1_beats",       beat_cnt,       19);

        // Contention after reset: order 0,1,2,3.
        do_reset();
        for (int s = 0; s < N; s++) set_route(s, 3 - s, 16 * s + 1);
        base = ack_log.size();
        dc = done_beats.size();
        router_start_req = 4'b1111;
        for (int k = 0; k < N; k++) wait_done("t2", 60);
        check("t2_acks", ack_log.size() - base, 4);
        for (int k = 0; k < N; k++) begin
            check("t2_order", ack_log[base + k], k);
            check("t2_beats", done_beats[dc + k], 19);
        end

        // Backpressure on output port 2 during cycles 5..9.
        set_route(0, 2, 'h155);
        router_start_req[0] = 1'b1;
        c0 = ncyc + 1;
        while (ncyc + 1 < c0 + 5) tick();
        full_output_port[2] = 1'b1;
        repeat (5) tick();
        full_output_port[2] = 1'b0;
        wait_done("t3", 60);
        check("t3_done_cyc", done_cyc, c0 + 26);
        check("t3_beats",    beat_cnt, 19);

        // Grant stall of 10 cycles on a loopback transfer 2 -> 2.
        set_route(2, 2, 'h2A5);
        router_start_req[2] = 1'b1;
        c0 = ncyc + 1;
        while (ncyc + 1 < c0 + 6) tick();
        write_gnt = 1'b0;
        repeat (5) tick();
        check("t4_wreq_stall", write_req, 1);
        check("t4_rd_stall",   rd_input_port, 0);
        repeat (5) tick();
        write_gnt = 1'b1;
        wait_done("t4", 60);
        check("t4_done_cyc", done_cyc, c0 + 31);
        check("t4_beats",    beat_cnt, 19);

        // Reset in the cycle of beat 7 of transfer 3 -> 0.
        set_route(3, 0, 'h3FF);
        router_start_req[3] = 1'b1;
        for (int g = 0; g < 60 && !(ack_cyc > 0 && ack_log[ack_log.size()-1] == 3 && beat_cnt >= 6); g++)
            tick();
        dc = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_beats_at_rst", beat_cnt, 7);
        check("t5_outs_zero", {router_start_ack, router_done, rd_input_port, we_output_port,
                               crossbar_en, crossbar_sel, write_req, busy, addr}, 0);
        repeat (4) tick();
        check("t5_no_done", done_cnt, dc);
        base = ack_log.size();
        router_start_req = 4'b1101;
        for (int k = 0; k < 3; k++) wait_done("t5", 60);
        check("t5_first_port0", ack_log[base], 0);
        check("t5_second",      ack_log[base + 1], 2);
        check("t5_third",       ack_log[base + 2], 3);

        // Source FIFO stuck empty: transfer stalls, then completes.
        set_route(1, 0, 'h011);
        empty_input_port[1] = 1'b1;
        router_start_req[1] = 1'b1;
        dc = done_cnt;
        repeat (40) tick();
`ifndef ROUTER_CTRL_TIMEOUT_EN
        check("t6_busy_stuck", busy, 1);
`endif
        check("t6_no_done", done_cnt, dc);
        empty_input_port[1] = 1'b0;
        wait_done("t6", 60);
        check("t6_beats", beat_cnt, 19);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
